// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - per-lane saturating accumulator with lowest-index-first drain
module psum_accum #(
  parameter int N_BUSLINE = 62,
  parameter int DW_DATA   = 8,
  parameter int DW_ACC    = 24,
  parameter int DW_PASS   = 8,
  localparam int IDX_W    = $clog2(N_BUSLINE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DW_PASS-1:0]             num_passes,
  input  logic                           in_beat,
  output logic                           in_ready,
  input  logic [N_BUSLINE*DW_DATA-1:0]   in_bus,
  input  logic [N_BUSLINE-1:0]           in_lane_valid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DW_ACC-1:0]              out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_sat,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int LANE_EXT = DW_ACC + 1 - DW_DATA;
  localparam logic [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
  localparam logic [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};

  state_t              state_q;
  state_t              state_d;
  logic [DW_PASS-1:0]  pass_cnt_q;
  logic                drain_first_q;
  logic [DW_ACC-1:0]   acc_q [N_BUSLINE];
  logic [N_BUSLINE-1:0] touched_q;
  logic [N_BUSLINE-1:0] sat_q;

  logic [DW_ACC-1:0]   acc_sum [N_BUSLINE];
  logic [N_BUSLINE-1:0] lane_ovf;
  logic [IDX_W-1:0]    sel_idx;
  logic                any_touched;
  logic                beat_acc;
  logic                drain_hs;

  assign any_touched = |touched_q;
  assign beat_acc    = (state_q == S_ACCUM) && in_beat;
  assign drain_hs    = out_valid && out_ready;

  // State register; also notes the first DRAIN cycle so an empty drain still spends one cycle before done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      drain_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_first_q <= (state_q != S_DRAIN) && (state_d == S_DRAIN);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_passes == '0) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat_acc && (pass_cnt_q == DW_PASS'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; element fields are muxed from registered lane state only
  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DRAIN) && any_touched;
    done      = (state_q == S_DRAIN) && !any_touched && !drain_first_q;
    out_idx   = out_valid ? sel_idx : '0;
    out_data  = out_valid ? acc_q[sel_idx] : '0;
    out_sat   = out_valid ? sat_q[sel_idx] : 1'b0;
  end

  // Beat counter: loaded when a run is armed, decremented on every accepted beat
  always_ff @(posedge clk) begin
    if (!reset) begin
      pass_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      pass_cnt_q <= num_passes;
    end else if (beat_acc) begin
      pass_cnt_q <= pass_cnt_q - DW_PASS'(1);
    end
  end

  // Per-lane widened add with clamp to the accumulator range on overflow
  always_comb begin
    for (int i = 0; i < N_BUSLINE; i++) begin
      logic [DW_DATA-1:0] lane;
      logic [DW_ACC:0]    sum;
      lane        = in_bus[i*DW_DATA +: DW_DATA];
      sum         = {acc_q[i][DW_ACC-1], acc_q[i]} + {{LANE_EXT{lane[DW_DATA-1]}}, lane};
      lane_ovf[i] = sum[DW_ACC] ^ sum[DW_ACC-1];
      if (lane_ovf[i]) begin
        acc_sum[i] = sum[DW_ACC] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_sum[i] = sum[DW_ACC-1:0];
      end
    end
  end

  // Lowest touched lane wins the drain port; scan high to low so the last hit is the lowest
  always_comb begin
    sel_idx = '0;
    for (int i = N_BUSLINE - 1; i >= 0; i--) begin
      if (touched_q[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Lane storage: accumulate valid lanes on a beat, clear the drained lane on handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q     <= '{default: '0};
      touched_q <= '0;
      sat_q     <= '0;
    end else begin
      for (int i = 0; i < N_BUSLINE; i++) begin
        if (beat_acc && in_lane_valid[i]) begin
          acc_q[i]     <= acc_sum[i];
          touched_q[i] <= 1'b1;
          if (lane_ovf[i]) begin
            sat_q[i] <= 1'b1;
          end
        end else if (drain_hs && (sel_idx == IDX_W'(i))) begin
          acc_q[i]     <= '0;
          touched_q[i] <= 1'b0;
          sat_q[i]     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// tb/tb_psum_accum.sv - directed self-checking bench for psum_accum
module tb_psum_accum;
  localparam int N  = 62;
  localparam int DW = 8;
  localparam int DA = 24;
  localparam int DS = 9;
  localparam int DP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            start;
  logic [DP-1:0]   num_passes;
  logic            in_beat;
  logic [N*DW-1:0] in_bus;
  logic [N-1:0]    in_lane_valid;
  logic            out_ready;

  logic            in_ready, out_valid, out_sat, busy, done;
  logic [DA-1:0]   out_data;
  logic [5:0]      out_idx;

  logic            s_in_ready, s_out_valid, s_out_sat, s_busy, s_done;
  logic [DS-1:0]   s_out_data;
  logic [5:0]      s_out_idx;

  psum_accum #(.N_BUSLINE(N), .DW_DATA(DW), .DW_ACC(DA), .DW_PASS(DP)) dut (
    .clk(clk), .reset(reset), .start(start), .num_passes(num_passes),
    .in_beat(in_beat), .in_ready(in_ready), .in_bus(in_bus), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_sat(out_sat), .busy(busy), .done(done)
  );

  psum_accum #(.N_BUSLINE(N), .DW_DATA(DW), .DW_ACC(DS), .DW_PASS(DP)) dut_s (
    .clk(clk), .reset(reset), .start(start), .num_passes(num_passes),
    .in_beat(in_beat), .in_ready(s_in_ready), .in_bus(in_bus), .in_lane_valid(in_lane_valid),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_idx(s_out_idx),
    .out_sat(s_out_sat), .busy(s_busy), .done(s_done)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int np;
    int la; int va;
    int lb; int vb;
    int e0_idx; int e0_dat;
    int e1_idx; int e1_dat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] mk_bus(input int la, input int va, input int lb, input int vb);
    logic [N*DW-1:0] b;
    b = '0;
    if (la >= 0) b[la*DW +: DW] = DW'(va);
    if (lb >= 0) b[lb*DW +: DW] = DW'(vb);
    return b;
  endfunction

  function automatic logic [N-1:0] mk_valid(input int la, input int lb);
    logic [N-1:0] v;
    v = '0;
    if (la >= 0) v[la] = 1'b1;
    if (lb >= 0) v[lb] = 1'b1;
    return v;
  endfunction

  // all tasks are entered and left at a falling edge
  task automatic start_run(input int np);
    start = 1'b1;
    num_passes = DP'(np);
    @(negedge clk);
    start = 1'b0;
    num_passes = '0;
  endtask

  task automatic send_beat(input logic [N*DW-1:0] b, input logic [N-1:0] v);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("beat_wait_in_ready", in_ready, 1);
    in_beat = 1'b1;
    in_bus = b;
    in_lane_valid = v;
    @(negedge clk);
    in_beat = 1'b0;
    in_bus = '0;
    in_lane_valid = '0;
  endtask

  task automatic take(input string nm, input int idx, input int dat, input int sat);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_idx"}, out_idx, idx);
    chk({nm, "_data"}, $signed(out_data), dat);
    chk({nm, "_sat"}, out_sat, sat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_done(input string nm);
    chk({nm, "_done_pulse"}, done, 1);
    chk({nm, "_done_no_valid"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_done_low"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_out_idx"}, out_idx, 0);
    chk({nm, "_out_sat"}, out_sat, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{np: 1, la: 3,  va: 5,    lb: 60, vb: -7, e0_idx: 3,  e0_dat: 5,   e1_idx: 60, e1_dat: -7};
    vecs[1] = '{np: 2, la: 61, va: -128, lb: 0,  vb: 100, e0_idx: 0, e0_dat: 200, e1_idx: 61, e1_dat: -256};
    vecs[2] = '{np: 3, la: 10, va: 127,  lb: 11, vb: -1, e0_idx: 10, e0_dat: 381, e1_idx: 11, e1_dat: -3};
    vecs[3] = '{np: 5, la: 30, va: -100, lb: 2,  vb: 1,  e0_idx: 2,  e0_dat: 5,   e1_idx: 30, e1_dat: -500};

    reset = 1'b0; start = 1'b0; num_passes = '0; in_beat = 1'b0;
    in_bus = '0; in_lane_valid = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_s_out_data", s_out_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // table-driven two-lane runs
    for (int t = 0; t < 4; t++) begin
      start_run(vecs[t].np);
      chk($sformatf("v%0d_busy", t), busy, 1);
      chk($sformatf("v%0d_in_ready", t), in_ready, 1);
      for (int p = 0; p < vecs[t].np; p++) begin
        send_beat(mk_bus(vecs[t].la, vecs[t].va, vecs[t].lb, vecs[t].vb),
                  mk_valid(vecs[t].la, vecs[t].lb));
      end
      chk($sformatf("v%0d_in_ready_low", t), in_ready, 0);
      chk($sformatf("v%0d_drain_latency", t), out_valid, 1);
      take($sformatf("v%0d_e0", t), vecs[t].e0_idx, vecs[t].e0_dat, 0);
      take($sformatf("v%0d_e1", t), vecs[t].e1_idx, vecs[t].e1_dat, 0);
      expect_done($sformatf("v%0d", t));
    end

    // multi-pass with idle cycles that carry lane data but no beat
    start_run(4);
    for (int p = 0; p < 4; p++) begin
      send_beat(mk_bus(0, 127, -1, 0), mk_valid(0, -1));
      if (p < 3) begin
        in_bus = mk_bus(0, 127, 1, 50);
        in_lane_valid = mk_valid(0, 1);
        repeat (2) @(negedge clk);
        in_bus = '0;
        in_lane_valid = '0;
      end
    end
    chk("mp_s_data", $signed(s_out_data), 255);
    chk("mp_s_sat", s_out_sat, 1);
    take("mp", 0, 508, 0);
    expect_done("mp");

    // positive saturation on the narrow instance
    start_run(3);
    for (int p = 0; p < 3; p++) send_beat(mk_bus(1, 127, -1, 0), mk_valid(1, -1));
    chk("satp_s_idx", s_out_idx, 1);
    chk("satp_s_data", $signed(s_out_data), 255);
    chk("satp_s_sat", s_out_sat, 1);
    take("satp", 1, 381, 0);
    expect_done("satp");

    // negative saturation on the narrow instance
    start_run(3);
    for (int p = 0; p < 3; p++) send_beat(mk_bus(1, -128, -1, 0), mk_valid(1, -1));
    chk("satn_s_data", $signed(s_out_data), -256);
    chk("satn_s_sat", s_out_sat, 1);
    take("satn", 1, -384, 0);
    expect_done("satn");

    // backpressure, with a start pulse during DRAIN that must be ignored
    start_run(1);
    send_beat(mk_bus(4, 20, 40, -33), mk_valid(4, 40));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_idx", c), out_idx, 4);
      chk($sformatf("bp%0d_data", c), $signed(out_data), 20);
      if (c == 2) begin
        start = 1'b1;
        num_passes = 8'd9;
      end
      @(negedge clk);
      start = 1'b0;
      num_passes = '0;
    end
    take("bp_e0", 4, 20, 0);
    take("bp_e1", 40, -33, 0);
    expect_done("bp");
    @(negedge clk);
    chk("bp_start_ignored", busy, 0);

    // zero passes: one empty DRAIN cycle, then done, then idle
    start_run(0);
    chk("zp_busy", busy, 1);
    chk("zp_in_ready", in_ready, 0);
    chk("zp_no_valid0", out_valid, 0);
    chk("zp_done_early", done, 0);
    @(negedge clk);
    chk("zp_done", done, 1);
    chk("zp_no_valid1", out_valid, 0);
    @(negedge clk);
    chk("zp_done_low", done, 0);
    chk("zp_idle", busy, 0);

    // a beat with no valid lanes still counts
    start_run(2);
    send_beat(mk_bus(5, 9, -1, 0), mk_valid(5, -1));
    chk("inv_still_accum", in_ready, 1);
    send_beat(mk_bus(5, 9, 6, 9), '0);
    chk("inv_in_ready_low", in_ready, 0);
    take("inv", 5, 9, 0);
    expect_done("inv");

    // reset in the middle of ACCUM discards partial sums
    start_run(4);
    send_beat(mk_bus(7, 50, -1, 0), mk_valid(7, -1));
    send_beat(mk_bus(7, 50, -1, 0), mk_valid(7, -1));
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    reset = 1'b1;
    start_run(1);
    send_beat(mk_bus(9, 3, -1, 0), mk_valid(9, -1));
    take("rst_new", 9, 3, 0);
    expect_done("rst_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_accum.md
# psum_accum

Output accumulation stage placed directly downstream of `core`. Each accepted beat adds the `core` fan-tree bus lanes whose valid bits are set into per-lane saturating accumulators. After a programmed number of beats, the block drains only the touched lanes, one lane per cycle, over a valid/ready port. It turns `core`'s per-tile partial sums into final output elements for writeback.

## Interface
Parameters:
- N_BUSLINE, 62, lane count; equals `core` N_BUSLINE (2*(N_UNIT-1))
- DW_DATA, 8, signed lane width of `core` out_bus
- DW_ACC, 24, signed accumulator and output width; must be >= DW_DATA+1
- DW_PASS, 8, width of the beat-count field

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low; reset occurs when low at a rising edge of clk
- start  in  1  one-cycle pulse; arms a new accumulation
- num_passes  in  DW_PASS  beats to accept; sampled only when start is taken
- in_beat  in  1  `core` output is valid this cycle
- in_ready  out  1  high only in ACCUM
- in_bus  in  N_BUSLINE*DW_DATA  signed lanes from `core` out_bus; lane i is bits [i*DW_DATA +: DW_DATA]
- in_lane_valid  in  N_BUSLINE  from `core` out_valid
- out_valid  out  1  drain element present
- out_ready  in  1  downstream accepts
- out_data  out  DW_ACC  accumulated lane value, signed
- out_idx  out  6  lane index of out_data; width is clog2(N_BUSLINE)
- out_sat  out  1  this lane saturated at least once
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last drain handshake

## Operation
- The FSM has three states: IDLE, ACCUM, DRAIN.
- IDLE:
  - start loads pass_cnt <= num_passes. It moves to ACCUM, or to DRAIN if num_passes == 0.
  - in_beat is ignored.
- ACCUM:
  - A beat is accepted when in_beat && in_ready.
  - On each accepted beat, every lane i with in_lane_valid[i]=1 does: acc[i] <= sat(acc[i] + sext(lane i)), touched[i] <= 1.
  - If the true sum lies outside [-2^(DW_ACC-1), 2^(DW_ACC-1)-1], acc clamps to the nearer bound and sat[i] <= 1.
  - Lanes with in_lane_valid[i]=0 are unchanged.
  - Each accepted beat decrements pass_cnt, whether or not any lane is valid. The beat that brings pass_cnt to 0 moves the FSM to DRAIN.
- DRAIN:
  - out_valid=1 whenever any touched bit is set. out_idx is the lowest set touched index; out_data and out_sat come from that lane.
  - On each out_valid && out_ready handshake, that lane's touched, acc and sat clear.
  - When no touched bits remain (including entry with none set), done=1 for one cycle, then IDLE.
  - out_data/out_idx/out_sat must hold stable while out_valid && !out_ready.
- start outside IDLE is ignored. Setting num_passes has no effect outside IDLE.
- Reset clears all acc, touched, sat and pass_cnt. The FSM goes to IDLE. All outputs go to 0 (in_ready, out_valid, out_data, out_idx, out_sat, busy, done). A reset mid-ACCUM or mid-DRAIN discards all partial data.
- When reset and start are both asserted at the same edge, reset wins.

## Timing
- start at edge T: busy=1 and in_ready=1 from T+1. This leaves a one-cycle bubble after start.
- A beat accepted at edge T is visible in acc after T.
- The final beat at edge T: in_ready=0 and out_valid=1 (if anything is touched) from T+1. Drain latency is 1 cycle.
- With out_ready held high, the block produces one element per cycle, giving M cycles for M touched lanes.
- The last handshake at edge T gives done=1 during T+1 and busy=0 from T+2. A start sampled at T+2 is accepted.
- num_passes == 0: start at T gives DRAIN at T+1 with nothing touched, done=1 at T+2, and IDLE at T+3.
- The lowest-index search is combinational over touched, reading registered state only. out_data, out_idx and out_sat are driven from registers via mux. There is no combinational path from in_* to out_*.

## Test plan
- Single beat: num_passes=1, lane 3 = +5, lane 60 = -7, all others invalid. Expect 2 outputs: (idx 3, +5), then (idx 60, -7), then done.
- Multi-pass sum: num_passes=4, lane 0 = +127 on every beat. Expect (idx 0, 508, sat=0). Interleave in_beat=0 idle cycles and verify no extra accumulation.
- Saturation: DW_ACC=9, 3 beats of lane 1 = +127. Expect out_data=255, out_sat=1. Repeat with -128 to get -256.
- Backpressure: hold out_ready=0 for 5 cycles during DRAIN. out_data and out_idx must stay stable and no element may be lost or duplicated.
- Edge cases:
  - num_passes=0 gives done with no out_valid.
  - A beat carrying all lanes invalid still counts toward num_passes.
  - start during DRAIN is ignored.
- Reset mid-ACCUM: after 2 of 4 beats, pulse reset low. All outputs read 0 the next cycle. A new 1-pass run then outputs only that run's values.
